// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg
//   Shared definitions for the cacheline <-> physical-memory burst protocol:
//   the adaptor FSM state type, line/beat geometry, and line/beat typedefs
//   used by the cache, the adaptor and the bench.
package mem_burst_pkg;

    localparam int LINE_BITS   = 256;
    localparam int BEAT_BITS   = 64;
    localparam int BEATS       = LINE_BITS / BEAT_BITS;
    localparam int OFFSET_BITS = 5;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } burst_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Turns one cacheline read or write from the last-level cache into a
//   BEATS-beat burst on the physical-memory port, then pulses resp_o for one
//   cycle back to the cache.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   line_i       : write data from cache (captured at request)
//   line_o       : read data to cache (valid while resp_o, held afterwards)
//   address_i    : line address from cache (captured at request)
//   read_i       : line read request (level, read wins over write)
//   write_i      : line write request (level)
//   resp_o       : one-cycle completion pulse
//   burst_i      : read beat from memory
//   burst_o      : write beat to memory (slot selected by beat counter)
//   address_o    : burst address, line-offset bits forced to zero
//   read_o       : burst read request to memory
//   write_o      : burst write request to memory
//   resp_i       : memory beat strobe, one beat per high cycle
module cacheline_adaptor #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LINE_BITS-1:0] line_i,
    output logic [LINE_BITS-1:0] line_o,
    input  logic [ADDR_BITS-1:0] address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    output logic                 resp_o,
    input  logic [BEAT_BITS-1:0] burst_i,
    output logic [BEAT_BITS-1:0] burst_o,
    output logic [ADDR_BITS-1:0] address_o,
    output logic                 read_o,
    output logic                 write_o,
    input  logic                 resp_i
);
    import mem_burst_pkg::*;

    localparam int BEATS = LINE_BITS / BEAT_BITS;
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_BITS / 8);
    // Clears the byte-within-line bits so memory always sees a line-aligned address.
    localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS - 1);

    burst_state_t                          state_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic [ADDR_BITS-1:0]                  addr_q;
    // Both line registers are beat-indexed; beat 0 is the least-significant slot.
    logic [BEATS-1:0][BEAT_BITS-1:0]       rline_q;
    logic [BEATS-1:0][BEAT_BITS-1:0]       wline_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rline_q <= '0;
            wline_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Read has priority; a simultaneous write is dropped.
                    if (read_i) begin
                        addr_q  <= address_i & ~OFF_MASK;
                        cnt_q   <= '0;
                        state_q <= ST_READ;
                    end else if (write_i) begin
                        addr_q  <= address_i & ~OFF_MASK;
                        wline_q <= line_i;
                        cnt_q   <= '0;
                        state_q <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (resp_i) begin
                        rline_q[cnt_q] <= burst_i;
                        // Counter wraps to zero on the final beat.
                        cnt_q          <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) state_q <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register, so they
    // cannot glitch and drop in the same cycle resp_o rises.
    assign read_o    = (state_q == ST_READ);
    assign write_o   = (state_q == ST_WRITE);
    assign resp_o    = (state_q == ST_DONE);
    assign address_o = addr_q;
    assign line_o    = rline_q;
    assign burst_o   = wline_q[cnt_q];

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;
    import mem_burst_pkg::*;

    logic        clk, rst;
    line_t       line_i, line_o;
    logic [31:0] address_i, address_o;
    logic        read_i, write_i, resp_o;
    beat_t       burst_i, burst_o;
    logic        read_o, write_o, resp_i;

    cacheline_adaptor #(.LINE_BITS(256), .BEAT_BITS(64), .ADDR_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Transaction-level model: the current burst is described by the cycle
    // its request is sampled into (m_s), the cycles its beats are presented
    // (m_b), and the cycle the completion must be seen (m_done).
    bit          started = 1'b0;
    bit          m_act = 1'b0;
    bit          m_rd = 1'b0;
    int          m_s = 0, m_done = 0;
    int          m_b[4];
    line_t       m_data = '0;
    line_t       exp_line = '0;
    logic [31:0] exp_addr = '0;
    int          rdo_cnt = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            if (rst) begin
                chk("rst read_o", 256'(read_o), 256'(0));
                chk("rst write_o", 256'(write_o), 256'(0));
                chk("rst resp_o", 256'(resp_o), 256'(0));
                chk("rst line_o", line_o, 256'(0));
                chk("rst address_o", 256'(address_o), 256'(0));
            end else begin
                bit er, ew, eresp;
                int n;
                er    = m_act &&  m_rd && cyc >= m_s && cyc < m_done;
                ew    = m_act && !m_rd && cyc >= m_s && cyc < m_done;
                eresp = m_act && cyc == m_done;
                chk("read_o", 256'(read_o), 256'(er));
                chk("write_o", 256'(write_o), 256'(ew));
                chk("resp_o", 256'(resp_o), 256'(eresp));
                chk("address_o", 256'(address_o), 256'(exp_addr));
                chk("read_o&write_o", 256'(read_o & write_o), 256'(0));
                if (!(m_act && m_rd && cyc > m_b[0] && cyc < m_done))
                    chk("line_o", line_o, exp_line);
                if (ew) begin
                    n = 0;
                    for (int j = 0; j < 4; j++) if (m_b[j] < cyc) n++;
                    chk("burst_o", 256'(burst_o), 256'(m_data[n*64 +: 64]));
                end
            end
            if (read_o) rdo_cnt++;
        end
    end

    // Issues one line request and plays the memory side. Called and returns
    // just after a rising edge. Beat j is presented in cycle m_s+1+lat+off_j.
    task automatic txn(input bit rd, input bit both, input logic [31:0] addr,
                       input line_t data, input int lat,
                       input int o0, input int o1, input int o2, input int o3,
                       input bit abort2);
        int b[4];
        int s;
        s = cyc + 1;
        b[0] = s + 1 + lat + o0;
        b[1] = s + 1 + lat + o1;
        b[2] = s + 1 + lat + o2;
        b[3] = s + 1 + lat + o3;
        m_rd = rd; m_s = s; m_done = b[3] + 1; m_b = b; m_data = data;
        m_act = 1'b1; rdo_cnt = 0;
        read_i    = rd | both;
        write_i   = ~rd | both;
        address_i = addr;
        line_i    = rd ? ~data : data;
        resp_i    = 1'b0;
        if (both) $display("[TB] note: read_i and write_i both high at cycle %0d (cache protocol error, expect read)", cyc);
        forever begin
            @(posedge clk); #1;
            if (abort2 && cyc == b[1] + 1) begin
                m_act = 1'b0; exp_line = '0; exp_addr = '0;
                read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
                rst = 1'b1;
                #1;
                chk("abort read_o", 256'(read_o), 256'(0));
                chk("abort line_o", line_o, 256'(0));
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (cyc == s) begin
                exp_addr  = {addr[31:5], 5'b0};
                // Changes while busy must be ignored.
                address_i = ~addr;
                line_i    = ~line_i;
            end
            resp_i  = 1'b0;
            burst_i = 64'hBADB_ADBA_DBAD_BADB;
            for (int j = 0; j < 4; j++)
                if (cyc == b[j]) begin
                    resp_i = 1'b1;
                    if (rd) burst_i = data[j*64 +: 64];
                end
            if (cyc == m_done) begin
                read_i = 1'b0; write_i = 1'b0;
                if (rd) exp_line = data;
            end
            if (cyc == m_done + 1) return;
        end
    endtask

    task automatic idle(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            resp_i  = toggle ? ~resp_i : 1'b0;
            burst_i = 64'h5A5A_5A5A_5A5A_5A5A;
        end
        resp_i = 1'b0;
    endtask

    localparam line_t L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam line_t LW = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    localparam line_t L2 = {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
                            64'h1357_9BDF_0246_8ACE, 64'h0123_4567_89AB_CDEF};
    localparam line_t L3 = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                            64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset read_o", 256'(read_o), 256'(0));
        chk("reset write_o", 256'(write_o), 256'(0));
        chk("reset resp_o", 256'(resp_o), 256'(0));
        chk("reset address_o", 256'(address_o), 256'(0));
        chk("reset line_o", line_o, 256'(0));
        chk("reset burst_o", 256'(burst_o), 256'(0));
        started = 1'b1;
        rst = 1'b0;
        idle(2, 1'b0);

        // Contiguous read, L=10.
        txn(1'b1, 1'b0, 32'h0000_8040, L1, 10, 0, 1, 2, 3, 1'b0);
        chk("read line literal", line_o, 256'h4444444444444444333333333333333322222222222222221111111111111111);
        chk("read_o cycles", 256'(rdo_cnt), 256'(15));
        idle(2, 1'b0);

        // Write with unaligned address; counter wraps back to slot 0.
        txn(1'b0, 1'b0, 32'h0000_1234, LW, 3, 0, 1, 2, 3, 1'b0);
        chk("write address literal", 256'(address_o), 256'h1220);
        chk("burst_o after wrap", 256'(burst_o), 256'hAAAAAAAAAAAAAAAA);
        idle(1, 1'b0);

        // Read with a gap in the beat strobes.
        txn(1'b1, 1'b0, 32'h0000_2000, L1, 2, 0, 1, 4, 5, 1'b0);
        chk("gapped line literal", line_o, 256'h4444444444444444333333333333333322222222222222221111111111111111);

        // Back-to-back: read issued the cycle after the write completes.
        txn(1'b0, 1'b0, 32'h0000_3010, LW, 1, 0, 2, 3, 4, 1'b0);
        txn(1'b1, 1'b0, 32'h0000_4000, L3, 0, 0, 1, 2, 3, 1'b0);
        chk("b2b line literal", line_o[63:0], 256'hCAFE000000000001);
        idle(2, 1'b0);

        // Reset after the second beat of a read, then a clean read.
        txn(1'b1, 1'b0, 32'h0000_5000, L2, 2, 0, 1, 2, 3, 1'b1);
        idle(2, 1'b0);
        txn(1'b1, 1'b0, 32'h0000_6060, L2, 1, 0, 1, 2, 3, 1'b0);
        chk("post-reset line literal", line_o[255:192], 256'hFEDCBA9876543210);
        idle(1, 1'b0);

        // Stray resp_i in idle, then simultaneous read+write runs as a read.
        idle(7, 1'b1);
        txn(1'b1, 1'b1, 32'h0000_7FFF, L3, 2, 0, 1, 2, 3, 1'b0);
        chk("both-high address literal", 256'(address_o), 256'h7FE0);
        idle(3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
